// File: rtl/fpga_carry_serial_ctrl.sv
// Bit-serial add sequencer that time-shares one external carry cell, LSB first.
// Optional subtract mode is enabled by defining CARRY_SERIAL_SUB_EN.
module fpga_carry_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
`ifdef CARRY_SERIAL_SUB_EN
  input  logic             sub_i,
`endif
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             busy_o,
  output logic             carry_err_o,
  output logic             cell_i0_o,
  output logic             cell_i1_o,
  output logic             cell_fcin_o,
  input  logic             cell_fcout_i
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_carry_q;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_carry_err;

  logic             w_idle;
  logic             w_run;
  logic             w_done;
  logic             w_accept;
  logic             w_last;
  logic             w_sum_bit;
  logic             w_maj;
  logic [WIDTH-1:0] w_b_load;
  logic             w_c_load;

  assign w_idle   = (r_state == S_IDLE);
  assign w_run    = (r_state == S_RUN);
  assign w_done   = (r_state == S_DONE);
  // Ready is masked while reset is held so every output reads 0 during reset.
  assign w_accept = req_valid_i & req_ready_o;
  assign w_last   = (r_bit_cnt == LAST_BIT);

  assign w_sum_bit = r_a_sh[0] ^ r_b_sh[0] ^ r_carry_q;
  assign w_maj     = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_carry_q) | (r_b_sh[0] & r_carry_q);

`ifdef CARRY_SERIAL_SUB_EN
  // A - B computed as A + ~B + 1; cout then means "no borrow".
  assign w_b_load = sub_i ? ~b_i : b_i;
  assign w_c_load = sub_i | cin_i;
`else
  assign w_b_load = b_i;
  assign w_c_load = cin_i;
`endif

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_DONE;
      S_DONE:  if (rsp_ready_i) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_sum_sh    <= '0;
      r_carry_q   <= 1'b0;
      r_bit_cnt   <= '0;
      r_carry_err <= 1'b0;
    end else if (w_accept) begin
      r_a_sh    <= a_i;
      r_b_sh    <= w_b_load;
      r_sum_sh  <= '0;
      r_carry_q <= w_c_load;
      r_bit_cnt <= '0;
    end else if (w_run) begin
      r_a_sh    <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh    <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_sum_sh  <= {w_sum_bit, r_sum_sh[WIDTH-1:1]};
      // The cell's carry drives the datapath even when it disagrees with the reference.
      r_carry_q <= cell_fcout_i;
      if (!w_last) begin
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
      if (cell_fcout_i != w_maj) begin
        r_carry_err <= 1'b1;
      end
    end
  end

  assign req_ready_o = w_idle & reset_ni;
  assign rsp_valid_o = w_done;
  assign busy_o      = w_run | w_done;
  assign sum_o       = w_done ? r_sum_sh : '0;
  assign cout_o      = w_done & r_carry_q;
  assign carry_err_o = r_carry_err;
  assign cell_i0_o   = w_run & r_a_sh[0];
  assign cell_i1_o   = w_run & r_b_sh[0];
  assign cell_fcin_o = w_run & r_carry_q;

endmodule

// File: tb/tb_fpga_carry_serial_ctrl.sv
// Randomized bench for fpga_carry_serial_ctrl with an arithmetic reference model and a
// behavioural carry cell that can be forced to return a wrong carry.
module tb_fpga_carry_serial_ctrl;
  localparam int W = 8;
`ifdef CARRY_SERIAL_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         req_valid;
  logic         req_ready_o;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         sub;
  logic         rsp_valid_o;
  logic         rsp_ready;
  logic [W-1:0] sum_o;
  logic         cout_o;
  logic         busy_o;
  logic         carry_err_o;
  logic         cell_i0_o;
  logic         cell_i1_o;
  logic         cell_fcin_o;
  logic         cell_fcout;
  logic         inject;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Behavioural carry cell: majority, optionally inverted to model a faulty cell.
  assign cell_fcout = ((cell_i0_o & cell_i1_o) | (cell_i0_o & cell_fcin_o) |
                       (cell_i1_o & cell_fcin_o)) ^ inject;

  fpga_carry_serial_ctrl #(.WIDTH(W)) dut (
    .clk_i        (clk),
    .reset_ni     (reset_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready_o),
    .a_i          (a_in),
    .b_i          (b_in),
    .cin_i        (cin),
`ifdef CARRY_SERIAL_SUB_EN
    .sub_i        (sub),
`endif
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready),
    .sum_o        (sum_o),
    .cout_o       (cout_o),
    .busy_o       (busy_o),
    .carry_err_o  (carry_err_o),
    .cell_i0_o    (cell_i0_o),
    .cell_i1_o    (cell_i1_o),
    .cell_fcin_o  (cell_fcin_o),
    .cell_fcout_i (cell_fcout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Carry entering bit k of a + b + c, from plain integer addition of the low k bits.
  function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic c, input int k);
    int m;
    int s;
    m = (1 << k) - 1;
    s = (int'(a) & m) + (int'(b) & m) + int'(c);
    return s[k];
  endfunction

  // Reference model: phase 0 idle, 1 serial run, 2 result held.
  int           m_phase;
  int           m_cnt;
  logic [W-1:0] m_a;
  logic [W-1:0] m_b;
  logic         m_c;
  logic [W:0]   m_res;
  logic         m_err;
  logic         m_corrupt;
  logic [W-1:0] b_eff;
  logic         c_eff;

  assign b_eff = (SUB_EN && sub) ? ~b_in : b_in;
  assign c_eff = (SUB_EN && sub) ? 1'b1 : cin;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase   <= 0;
      m_cnt     <= 0;
      m_err     <= 1'b0;
      m_corrupt <= 1'b0;
    end else begin
      case (m_phase)
        0: if (req_valid) begin
          m_a     <= a_in;
          m_b     <= b_eff;
          m_c     <= c_eff;
          m_res   <= {1'b0, a_in} + {1'b0, b_eff} + {{W{1'b0}}, c_eff};
          m_cnt   <= 0;
          m_phase <= 1;
        end
        1: begin
          if (inject) begin
            m_err     <= 1'b1;
            m_corrupt <= 1'b1;
          end
          if (m_cnt == W - 1) m_phase <= 2;
          else m_cnt <= m_cnt + 1;
        end
        default: if (rsp_ready) m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("req_ready", req_ready_o, reset_n && m_phase == 0);
    chk("rsp_valid", rsp_valid_o, m_phase == 2);
    chk("busy", busy_o, m_phase != 0);
    chk("carry_err", carry_err_o, m_err);
    chk("cell_i0", cell_i0_o, (m_phase == 1) ? m_a[m_cnt] : 1'b0);
    chk("cell_i1", cell_i1_o, (m_phase == 1) ? m_b[m_cnt] : 1'b0);
    if (!m_corrupt) begin
      chk("cell_fcin", cell_fcin_o, (m_phase == 1) ? carry_into(m_a, m_b, m_c, m_cnt) : 1'b0);
      chk("sum_o", sum_o, (m_phase == 2) ? m_res[W-1:0] : '0);
      chk("cout_o", cout_o, (m_phase == 2) ? m_res[W] : 1'b0);
    end
  end

  // Presents a request at posedge+1 and returns at posedge+1 just after the accept edge.
  task automatic do_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic s);
    req_valid = 1'b1;
    a_in = a;
    b_in = b;
    cin  = c;
    sub  = s;
    for (int i = 0; i < 50 && !req_ready_o; i++) begin
      @(posedge clk); #1;
    end
    chk("req_wait", req_ready_o, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic get_rsp(input logic [W-1:0] es, input logic ec, input bit lit, input int dly);
    for (int i = 0; i < 50 && !rsp_valid_o; i++) begin
      @(posedge clk); #1;
    end
    chk("rsp_wait", rsp_valid_o, 1'b1);
    if (lit) begin
      chk("lit_sum", sum_o, es);
      chk("lit_cout", cout_o, ec);
    end
    for (int i = 0; i < dly; i++) begin
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [W-1:0] seq;
    reset_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; inject = 1'b0;
    a_in = '0; b_in = '0; cin = 1'b0; sub = 1'b0;
    #3;
    chk("rst_ready", req_ready_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    #9 reset_n = 1'b1;
    #1 chk("rel_ready", req_ready_o, 1'b1);
    @(posedge clk); #1;

    // 0x0F + 0x01: latency and carry sequence into the cell.
    do_req(8'h0F, 8'h01, 1'b0, 1'b0);
    lat = 0;
    seq = '0;
    seq[0] = cell_fcin_o;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (rsp_valid_o) break;
      if (lat < W) seq[lat] = cell_fcin_o;
    end
    chk("latency", lat, 8);
    chk("fcin_seq", seq, 8'h1E);
    get_rsp(8'h10, 1'b0, 1, 0);

    do_req(8'hFF, 8'h01, 1'b0, 1'b0);
    get_rsp(8'h00, 1'b1, 1, 1);
    do_req(8'hFF, 8'hFF, 1'b1, 1'b0);
    get_rsp(8'hFF, 1'b1, 1, 0);

    // Backpressure with a second request waiting.
    do_req(8'h10, 8'h20, 1'b0, 1'b0);
    req_valid = 1'b1; a_in = 8'h21; b_in = 8'h43; cin = 1'b0;
    for (int i = 0; i < 50 && !rsp_valid_o; i++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      chk("hold_sum", sum_o, 8'h30);
      chk("hold_ready", req_ready_o, 1'b0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("idle_after_take", req_ready_o, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("second_accept", busy_o, 1'b1);
    get_rsp(8'h64, 1'b0, 1, 0);

    // Reset while the fourth bit is on the cell.
    do_req(8'hAA, 8'h55, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    #1;
    chk("abort_busy", busy_o, 1'b0);
    chk("abort_i0", cell_i0_o, 1'b0);
    chk("abort_ready", req_ready_o, 1'b0);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    do_req(8'h12, 8'h34, 1'b0, 1'b0);
    get_rsp(8'h46, 1'b0, 1, 0);

`ifdef CARRY_SERIAL_SUB_EN
    do_req(8'h05, 8'h07, 1'b1, 1'b1);
    get_rsp(8'hFE, 1'b0, 1, 0);
`endif

    for (int t = 0; t < 40; t++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        @(posedge clk); #1;
      end
      do_req(W'($urandom), W'($urandom), 1'($urandom), SUB_EN & 1'($urandom));
      get_rsp('0, 1'b0, 0, int'($urandom_range(0, 3)));
    end

    // Faulty carry for one serial cycle: sticky error until reset.
    do_req(8'h3C, 8'h0F, 1'b0, 1'b0);
    inject = 1'b1;
    @(posedge clk); #1;
    inject = 1'b0;
    chk("err_set", carry_err_o, 1'b1);
    get_rsp('0, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    chk("err_sticky", carry_err_o, 1'b1);
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
    #1 chk("err_cleared", carry_err_o, 1'b0);
    @(posedge clk); #1;
    do_req(8'h01, 8'h02, 1'b0, 1'b0);
    get_rsp(8'h03, 1'b0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
